// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: rising-edge tick prescaler, BCD MM:SS counter, IDLE/RUN/PAUSE/LAP FSM.
// Latency: one cycle from the edge sampling a tick rise or command to updated disp/state/wrap.
// Backpressure: none; command pulses and ticks are always accepted or dropped by priority/state.
module stopwatch_ctrl #(
    parameter int unsigned TICKS_PER_SEC = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        start_stop,
    input  logic        lap,
    input  logic        clear,
    output logic [15:0] disp,
    output logic [1:0]  state,
    output logic        running,
    output logic        wrap
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;
    localparam logic [1:0] LAP   = 2'd3;

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_SEC - 1);

    logic          tick_d;
    logic [PW-1:0] pre_q;
    logic [15:0]   time_q;
    logic [15:0]   frozen_q;
    logic [15:0]   time_inc;
    logic [1:0]    state_nx;
    logic          qtick;
    logic          count_en;
    logic          at_max;

    assign qtick    = tick & ~tick_d;
    assign running  = (state == RUN) || (state == LAP);
    assign count_en = qtick & running;
    assign at_max   = (time_q == 16'h5959);
    assign disp     = (state == LAP) ? frozen_q : time_q;

    // One-second BCD increment with all carries resolved combinationally.
    always_comb begin
        time_inc = time_q;
        if (time_q[3:0] != 4'd9) begin
            time_inc[3:0] = time_q[3:0] + 4'd1;
        end else begin
            time_inc[3:0] = 4'd0;
            if (time_q[7:4] != 4'd5) begin
                time_inc[7:4] = time_q[7:4] + 4'd1;
            end else begin
                time_inc[7:4] = 4'd0;
                if (time_q[11:8] != 4'd9) begin
                    time_inc[11:8] = time_q[11:8] + 4'd1;
                end else begin
                    time_inc[11:8] = 4'd0;
                    if (time_q[15:12] != 4'd5)
                        time_inc[15:12] = time_q[15:12] + 4'd1;
                    else
                        time_inc[15:12] = 4'd0;
                end
            end
        end
    end

    // clear beats start_stop beats lap; unlisted state/command pairs hold.
    always_comb begin
        state_nx = state;
        if (clear) begin
            state_nx = IDLE;
        end else if (start_stop) begin
            case (state)
                IDLE:    state_nx = RUN;
                RUN:     state_nx = PAUSE;
                PAUSE:   state_nx = RUN;
                LAP:     state_nx = PAUSE;
                default: state_nx = IDLE;
            endcase
        end else if (lap) begin
            if (state == RUN)
                state_nx = LAP;
            else if (state == LAP)
                state_nx = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            tick_d   <= 1'b1;
            pre_q    <= '0;
            time_q   <= '0;
            frozen_q <= '0;
            wrap     <= 1'b0;
        end else begin
            tick_d <= tick;
            state  <= state_nx;
            wrap   <= 1'b0;
            if (clear) begin
                pre_q    <= '0;
                time_q   <= '0;
                frozen_q <= '0;
            end else begin
                // Counting keys off the current state: a tick on RUN->PAUSE counts, on PAUSE->RUN it does not.
                if (count_en) begin
                    if (pre_q == PRE_MAX) begin
                        pre_q  <= '0;
                        time_q <= time_inc;
                        wrap   <= at_max;
                    end else begin
                        pre_q <= pre_q + PW'(1);
                    end
                end
                if (state_nx == LAP && state != LAP)
                    frozen_q <= time_q;
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboarded bench for stopwatch_ctrl: directed scenarios plus random commands/ticks against
// an integer-seconds reference model.
module tb_stopwatch_ctrl;

    localparam int TPS = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick = 1'b0;
    logic        start_stop = 1'b0;
    logic        lap = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] disp;
    logic [1:0]  state;
    logic        running;
    logic        wrap;

    int checks = 0;
    int errors = 0;

    logic [19:0] sb_q[$];

    // Reference model: time kept as total seconds, state as 0..3.
    int m_st = 0;
    int m_secs = 0;
    int m_pre = 0;
    int m_frozen = 0;
    bit m_prev = 1'b1;
    bit m_wrap = 1'b0;

    stopwatch_ctrl #(.TICKS_PER_SEC(TPS)) dut (
        .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .lap(lap),
        .clear(clear), .disp(disp), .state(state), .running(running), .wrap(wrap)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int s);
        int mm;
        int ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic model_step(input bit r, input bit t, input bit s, input bit l, input bit c);
        bit q;
        bit live;
        int old_secs;
        if (!r) begin
            m_st = 0; m_secs = 0; m_pre = 0; m_frozen = 0; m_prev = 1'b1; m_wrap = 1'b0;
            return;
        end
        q = t && !m_prev;
        m_prev = t;
        live = (m_st == 1) || (m_st == 3);
        old_secs = m_secs;
        m_wrap = 1'b0;
        if (c) begin
            m_st = 0; m_secs = 0; m_pre = 0; m_frozen = 0;
            return;
        end
        if (q && live) begin
            m_pre = m_pre + 1;
            if (m_pre == TPS) begin
                m_pre = 0;
                m_wrap = (m_secs == 3599);
                m_secs = (m_secs + 1) % 3600;
            end
        end
        if (s) begin
            m_st = (m_st == 1 || m_st == 3) ? 2 : 1;
        end else if (l) begin
            if (m_st == 1) begin
                m_st = 3;
                m_frozen = old_secs;
            end else if (m_st == 3) begin
                m_st = 1;
            end
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
    task automatic cyc(input bit r, input bit t, input bit s, input bit l, input bit c);
        @(negedge clk);
        rst = r; tick = t; start_stop = s; lap = l; clear = c;
        model_step(r, t, s, l, c);
        sb_q.push_back({to_bcd(m_st == 3 ? m_frozen : m_secs), 2'(m_st),
                        (m_st == 1 || m_st == 3), m_wrap});
    endtask

    task automatic pulse();
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every rising edge presents a new output word to compare.
    initial begin
        logic [19:0] exp_w;
        logic [19:0] act_w;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                exp_w = sb_q.pop_front();
                act_w = {disp, state, running, wrap};
                checks++;
                if (act_w !== exp_w) begin
                    errors++;
                    $display("FAIL sb @%0t: got disp=%h st=%0d run=%b wrap=%b, expected disp=%h st=%0d run=%b wrap=%b",
                             $time, act_w[19:4], act_w[3:2], act_w[1], act_w[0],
                             exp_w[19:4], exp_w[3:2], exp_w[1], exp_w[0]);
                end
            end
        end
    end

    initial begin
        // Reset state
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        chk("reset_disp", disp, 16'h0000);
        chk("reset_flags", {14'd0, state}, {14'd0, 2'd0});

        // Start then 20 ticks
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) pulse();
        settle();
        chk("run10_disp", disp, 16'h0010);
        chk("run10_state", {14'd0, state}, 16'd1);
        chk("run10_running", {15'd0, running}, 16'd1);

        // Count up to 59:59, then roll over
        for (int i = 0; i < 3589 * TPS; i++) pulse();
        settle();
        chk("pre_wrap_disp", disp, 16'h5959);
        pulse();
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        chk("wrap_disp", disp, 16'h0000);
        chk("wrap_high", {15'd0, wrap}, 16'd1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        chk("wrap_one_cycle", {15'd0, wrap}, 16'd0);
        chk("wrap_state", {14'd0, state}, 16'd1);

        // Lap freeze at 00:03, internal time keeps counting
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) pulse();
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) pulse();
        settle();
        chk("lap_frozen", disp, 16'h0003);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        settle();
        chk("lap_release", disp, 16'h0005);
        chk("lap_release_state", {14'd0, state}, 16'd1);

        // Pause with prescaler at 1, ticks discarded, resume from held prescaler
        pulse();
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) pulse();
        settle();
        chk("pause_state", {14'd0, state}, 16'd2);
        chk("pause_disp", disp, 16'h0005);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        pulse();
        settle();
        chk("resume_disp", disp, 16'h0006);

        // clear + start_stop + tick together
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        settle();
        chk("clear_state", {14'd0, state}, 16'd0);
        chk("clear_disp", disp, 16'h0000);
        chk("clear_wrap", {15'd0, wrap}, 16'd0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        chk("held_tick_once", disp, 16'h0000);
        pulse();
        settle();
        chk("held_then_pulse", disp, 16'h0001);

        // Tick high across reset release is not counted
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        pulse();
        settle();
        chk("rst_tick_nocount", disp, 16'h0000);
        chk("rst_release_run", {14'd0, state}, 16'd1);

        // Reset mid-LAP with all commands asserted
        for (int i = 0; i < 5; i++) pulse();
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        pulse();
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        settle();
        chk("rst_lap_out", {disp[13:0], state}, 16'h0000);
        chk("rst_lap_flags", {14'd0, running, wrap}, 16'd0);

        // Random stimulus against the model
        for (int i = 0; i < 6000; i++) begin
            cyc($urandom_range(299) != 0, 1'($urandom_range(1)), $urandom_range(24) == 0,
                $urandom_range(14) == 0, $urandom_range(149) == 0);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
        #3;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
